// File: rtl/pattern_ser_pkg.sv
// Shared definitions for the pattern serializer: FSM state encoding and gap counter width.
package pattern_ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10
    } state_t;

    localparam int GAP_CNT_W = 8;

endpackage

// File: rtl/pattern_ser_cnt.sv
// Loadable down counter that saturates at zero and flags when it is there.
module pattern_ser_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // load wins over dec; dec never takes the counter below zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pattern_serializer.sv
// Parallel-to-serial pattern transmitter, MSB first, with optional idle gap between words.
// Define PATTERN_SER_PARITY_EN to append an even-parity bit to every word.
module pattern_serializer
    import pattern_ser_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state_dbg
);

`ifdef PATTERN_SER_PARITY_EN
    localparam int SH_W = WIDTH + 1;
`else
    localparam int SH_W = WIDTH;
`endif
    localparam int                    CNT_W      = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]      BIT_LOAD   = CNT_W'(SH_W - 1);
    localparam int                    GAP_LOAD_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [GAP_CNT_W-1:0]  GAP_LOAD   = GAP_CNT_W'(GAP_LOAD_I);
    localparam bit                    GAPLESS    = (GAP_CYCLES == 0);

    state_t          state;
    logic [SH_W-1:0] shreg;
    logic [SH_W-1:0] load_word;
    logic            bit_zero;
    logic            gap_zero;
    logic            accept;
    logic            gap_load;

`ifdef PATTERN_SER_PARITY_EN
    assign load_word = {word_in, ^word_in};
`else
    assign load_word = word_in;
`endif

    // Handshake: a word transfers on any clk edge where word_valid && word_ready;
    // word_in is ignored otherwise and the sender must hold word_valid until then.
    always_comb begin
        word_ready = 1'b1;
        case (state)
            SHIFT:   word_ready = GAPLESS && bit_zero;
            GAP:     word_ready = 1'b0;
            default: word_ready = 1'b1;
        endcase
    end

    assign accept   = word_valid && word_ready;
    assign gap_load = (state == SHIFT) && bit_zero && !GAPLESS;

    pattern_ser_cnt #(.W(CNT_W)) u_bit_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept),
        .load_val (BIT_LOAD),
        .dec      (state == SHIFT),
        .zero     (bit_zero)
    );

    pattern_ser_cnt #(.W(GAP_CNT_W)) u_gap_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .dec      (state == GAP),
        .zero     (gap_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shreg      <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    if (bit_zero && accept) begin
                        shreg <= load_word;
                    end else begin
                        shreg <= shreg << 1;
                        if (bit_zero) begin
                            state      <= GAPLESS ? IDLE : GAP;
                            dout_valid <= 1'b0;
                            busy       <= !GAPLESS;
                        end
                    end
                end
                GAP: begin
                    if (gap_zero) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    if (accept) begin
                        shreg      <= load_word;
                        state      <= SHIFT;
                        dout_valid <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
            endcase
        end
    end

    // shreg is fully shifted out (all zero) whenever the block is not sending
    assign dout      = shreg[SH_W-1];
    assign done      = dout_valid && bit_zero;
    assign state_dbg = state;

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench: dut_a has a one-cycle gap, dut_b runs gapless; both share clk and reset_n.
module tb_pattern_serializer;

`ifdef PATTERN_SER_PARITY_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;

    logic [3:0] a_word = '0;
    logic       a_valid = 1'b0;
    logic       a_ready, a_dout, a_dv, a_done, a_busy;
    logic [1:0] a_st;

    logic [3:0] b_word = '0;
    logic       b_valid = 1'b0;
    logic       b_ready, b_dout, b_dv, b_done, b_busy;
    logic [1:0] b_st;

    logic [0:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    pattern_serializer #(.WIDTH(4), .GAP_CYCLES(1)) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .word_in    (a_word),
        .word_valid (a_valid),
        .word_ready (a_ready),
        .dout       (a_dout),
        .dout_valid (a_dv),
        .done       (a_done),
        .busy       (a_busy),
        .state_dbg  (a_st)
    );

    pattern_serializer #(.WIDTH(4), .GAP_CYCLES(0)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .word_in    (b_word),
        .word_valid (b_valid),
        .word_ready (b_ready),
        .dout       (b_dout),
        .dout_valid (b_dv),
        .done       (b_done),
        .busy       (b_busy),
        .state_dbg  (b_st)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic a_check_idle(input string tag);
        check({tag, "_dout"},  a_dout,  1'b0);
        check({tag, "_dv"},    a_dv,    1'b0);
        check({tag, "_done"},  a_done,  1'b0);
        check({tag, "_busy"},  a_busy,  1'b0);
        check({tag, "_ready"}, a_ready, 1'b1);
        check({tag, "_state"}, a_st == 2'b00, 1'b1);
    endtask

    task automatic a_check_gap(input string tag);
        check({tag, "_dout"},  a_dout,  1'b0);
        check({tag, "_dv"},    a_dv,    1'b0);
        check({tag, "_ready"}, a_ready, 1'b0);
        check({tag, "_busy"},  a_busy,  1'b1);
        check({tag, "_state"}, a_st == 2'b10, 1'b1);
    endtask

    // Word was accepted at the previous posedge; consume exp_q bit by bit.
    task automatic a_expect_frame(input string tag);
        int n;
        n = exp_q.size();
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            check({tag, "_dout"},  a_dout,  exp_q.pop_front());
            check({tag, "_dv"},    a_dv,    1'b1);
            check({tag, "_done"},  a_done,  i == n);
            check({tag, "_ready"}, a_ready, 1'b0);
            check({tag, "_busy"},  a_busy,  1'b1);
        end
    endtask

    task automatic a_send(input logic [3:0] w);
        a_word  = w;
        a_valid = 1'b1;
        @(posedge clk);
        #1 a_valid = 1'b0;
    endtask

    initial begin
        // reset held: inputs toggle, nothing may be accepted
        for (int i = 0; i < 3; i++) begin
            a_word = 4'b1111; a_valid = 1'b1;
            b_word = 4'b1010; b_valid = 1'b1;
            @(negedge clk);
            a_check_idle("rst");
            check("rst_b_dv",    b_dv,    1'b0);
            check("rst_b_ready", b_ready, 1'b1);
            check("rst_b_busy",  b_busy,  1'b0);
            a_valid = 1'b0; b_valid = 1'b0;
        end
        reset_n = 1'b1;
        @(negedge clk);
        a_check_idle("post_rst");
        check("post_rst_b_busy", b_busy, 1'b0);

        // 1010 through the one-gap instance
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
`ifdef PATTERN_SER_PARITY_EN
        exp_q.push_back(1'b0);
`endif
        a_send(4'b1010);
        a_expect_frame("w1010");
        @(negedge clk);
        a_check_gap("w1010_gap");
        // offer 1111 during the gap, valid held
        a_word = 4'b1111; a_valid = 1'b1;
        @(negedge clk);
        a_check_idle("gap_wait");
        @(posedge clk);
        #1 a_valid = 1'b0;
        exp_q.push_back(1'b1); exp_q.push_back(1'b1);
        exp_q.push_back(1'b1); exp_q.push_back(1'b1);
`ifdef PATTERN_SER_PARITY_EN
        exp_q.push_back(1'b0);
`endif
        a_expect_frame("w1111");
        @(negedge clk);
        a_check_gap("w1111_gap");
        @(negedge clk);
        a_check_idle("w1111_idle");

        // gapless back-to-back 1010,1010 on dut_b
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(1'b1); exp_q.push_back(1'b0);
            exp_q.push_back(1'b1); exp_q.push_back(1'b0);
`ifdef PATTERN_SER_PARITY_EN
            exp_q.push_back(1'b0);
`endif
        end
        b_word = 4'b1010; b_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 2 * NB; c++) begin
            @(negedge clk);
            check("b2b_dout",  b_dout,  exp_q.pop_front());
            check("b2b_dv",    b_dv,    1'b1);
            check("b2b_done",  b_done,  (c == NB) || (c == 2 * NB));
            check("b2b_ready", b_ready, (c == NB) || (c == 2 * NB));
            check("b2b_busy",  b_busy,  1'b1);
            if (c == NB + 1) begin
                b_valid = 1'b0;
                b_word  = 4'b0101;
            end
        end
        @(negedge clk);
        check("b2b_end_dv",    b_dv,    1'b0);
        check("b2b_end_busy",  b_busy,  1'b0);
        check("b2b_end_ready", b_ready, 1'b1);
        check("b2b_end_state", b_st == 2'b00, 1'b1);

        // reset pulse after two bits of 1100
        a_send(4'b1100);
        @(negedge clk);
        check("mid_b0", a_dout, 1'b1);
        @(negedge clk);
        check("mid_b1", a_dout, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        a_check_idle("mid_rst");
        #1 reset_n = 1'b1;
        @(negedge clk);
        a_check_idle("mid_rel");
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
`ifdef PATTERN_SER_PARITY_EN
        exp_q.push_back(1'b0);
`endif
        a_send(4'b0110);
        a_expect_frame("w0110");
        @(negedge clk);
        a_check_gap("w0110_gap");
        @(negedge clk);
        a_check_idle("w0110_idle");

        // 1011: parity bit 1 when enabled
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        exp_q.push_back(1'b1); exp_q.push_back(1'b1);
`ifdef PATTERN_SER_PARITY_EN
        exp_q.push_back(1'b1);
`endif
        a_send(4'b1011);
        a_expect_frame("w1011");
        @(negedge clk);
        a_check_gap("w1011_gap");
        @(negedge clk);
        a_check_idle("w1011_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
